// File: rtl/udp_adnet_depkt_pkg.sv
// Shared types for the UDP sample depacketizer:
// parser/playout state enums, frame limits, start word.
package udp_adnet_depkt_pkg;

    localparam int          MAX_LEN       = 1024;
    localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        LEN_H,
        LEN_L,
        DATA,
        DROP
    } parse_st_t;

    typedef enum logic {
        WAIT_FILL,
        PLAY
    } play_st_t;

endpackage

// File: rtl/sync_fifo_byte.sv
// Single-clock byte FIFO with registered read data.
// Ports: i_clk, i_rst_n, i_wr_en/i_wr_data, i_rd_en, o_rd_data,
//        o_full, o_empty, o_level (occupancy, AW+1 bits).
module sync_fifo_byte #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    output logic [7:0]    o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic [7:0]    r_rd_data;
    logic          w_wr;
    logic          w_rd;

    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign o_full    = r_level[AW];
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_rd_data;

    // A write into a full FIFO is lost even if a read frees a slot.
    assign w_wr = i_wr_en & ~o_full;
    assign w_rd = i_rd_en & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd) begin
                r_rp      <= r_rp + AW'(1);
                r_rd_data <= r_mem[r_rp];
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/udp_adnet_depkt.sv
// UDP payload depacketizer: parses MAGIC/LEN framed samples into a FIFO
// and plays them out to a DAC at one sample per RATE_DIV clocks.
// Ports: sys_clk, sys_rst_n; rec_en/rec_data/rec_pkt_done payload in;
//        da_en/da_data DAC out; underrun, pkt_cnt, err_cnt, fifo_level status.
module udp_adnet_depkt
    import udp_adnet_depkt_pkg::*;
#(
    parameter logic [15:0] MAGIC    = MAGIC_DEFAULT,
    parameter int          FIFO_AW  = 8,
    parameter int          RATE_DIV = 4,
    parameter int          PREFILL  = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               rec_en,
    input  logic [7:0]         rec_data,
    input  logic               rec_pkt_done,
    output logic               da_en,
    output logic [7:0]         da_data,
    output logic               underrun,
    output logic [15:0]        pkt_cnt,
    output logic [7:0]         err_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [7:0]  L_DIV_MAX = 8'(RATE_DIV - 1);
    localparam logic [31:0] L_PREFILL = 32'(PREFILL);

    parse_st_t   r_pst;
    parse_st_t   w_pst_byte;
    parse_st_t   w_pst_nxt;
    logic [10:0] r_rem;
    logic [10:0] w_rem_nxt;
    logic [10:0] w_rem_dec;
    logic [7:0]  r_len_h;
    logic [15:0] w_len;
    logic [15:0] r_pkt_cnt;
    logic [7:0]  r_err_cnt;
    logic        w_pkt_inc;
    logic        w_err_inc;
    logic        w_fifo_wr;

    play_st_t    r_wst;
    play_st_t    w_wst_nxt;
    logic [7:0]  r_div;
    logic        w_tick;
    logic        w_fifo_rd;
    logic        w_urun;
    logic        r_da_en;
    logic        r_underrun;

    logic        w_full;
    logic        w_empty;

    assign w_len     = {r_len_h, rec_data};
    assign w_rem_dec = r_rem - 11'd1;

    // Parser: the byte is consumed first, then rec_pkt_done forces IDLE.
    // A done that leaves the frame still in DATA means it was truncated.
    always_comb begin
        w_pst_byte = r_pst;
        w_rem_nxt  = r_rem;
        w_fifo_wr  = 1'b0;
        w_pkt_inc  = 1'b0;
        w_err_inc  = 1'b0;
        if (rec_en) begin
            unique case (r_pst)
                IDLE: begin
                    w_pst_byte = (rec_data == MAGIC[15:8]) ? HDR1 : DROP;
                end
                HDR1: begin
                    if (rec_data == MAGIC[7:0]) begin
                        w_pst_byte = LEN_H;
                    end else begin
                        w_pst_byte = DROP;
                        w_err_inc  = 1'b1;
                    end
                end
                LEN_H: begin
                    w_pst_byte = LEN_L;
                end
                LEN_L: begin
                    if (w_len == 16'd0 || w_len > 16'(MAX_LEN)) begin
                        w_pst_byte = DROP;
                        w_err_inc  = 1'b1;
                    end else begin
                        w_rem_nxt  = w_len[10:0];
                        w_pst_byte = DATA;
                    end
                end
                DATA: begin
                    w_fifo_wr = ~w_full;
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == 11'd0) begin
                        w_pst_byte = DROP;
                        w_pkt_inc  = 1'b1;
                    end
                end
                DROP: begin
                    w_pst_byte = DROP;
                end
                default: begin
                    w_pst_byte = DROP;
                end
            endcase
        end
        w_pst_nxt = w_pst_byte;
        if (rec_pkt_done) begin
            if (w_pst_byte == DATA) begin
                w_err_inc = 1'b1;
            end
            w_pst_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pst     <= IDLE;
            r_rem     <= '0;
            r_len_h   <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_pst <= w_pst_nxt;
            r_rem <= w_rem_nxt;
            if (rec_en && r_pst == LEN_H) begin
                r_len_h <= rec_data;
            end
            if (w_pkt_inc) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_err_inc && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign w_tick = (r_div == L_DIV_MAX);

    always_comb begin
        w_wst_nxt = r_wst;
        w_fifo_rd = 1'b0;
        w_urun    = 1'b0;
        unique case (r_wst)
            WAIT_FILL: begin
                if (32'(fifo_level) >= L_PREFILL) begin
                    w_wst_nxt = PLAY;
                end
            end
            PLAY: begin
                if (w_tick) begin
                    if (w_empty) begin
                        w_urun    = 1'b1;
                        w_wst_nxt = WAIT_FILL;
                    end else begin
                        w_fifo_rd = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wst      <= WAIT_FILL;
            r_div      <= '0;
            r_da_en    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_wst      <= w_wst_nxt;
            r_div      <= w_tick ? 8'd0 : r_div + 8'd1;
            r_da_en    <= w_fifo_rd;
            r_underrun <= r_underrun | w_urun;
        end
    end

    // The FIFO's registered read port doubles as the held DAC sample.
    sync_fifo_byte #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (rec_data),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (da_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign da_en    = r_da_en;
    assign underrun = r_underrun;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;

endmodule
